// File: rtl/uart_pkg.sv
// Purpose: shared UART definitions (receiver FSM state encoding, baud timing helpers).
// Ports: none (package).
package uart_pkg;

  localparam int unsigned BAUD_W = 16;
  localparam int unsigned BIT_W  = 3;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  // Bit period in system clock cycles; shared with the transmitter.
  function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Offset from a start-bit edge to its midpoint.
  function automatic int unsigned half_bit(input int unsigned clk_hz,
                                           input int unsigned baud);
    return cycles_per_bit(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Purpose: receiver-side serial line plus received-byte outputs.
// Signals: rx (serial in, idle high), data[7:0], valid, frame_err, busy.
// Modports: master = the receiver, slave = the line driver / byte consumer.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (input rx, output data, output valid, output frame_err, output busy);
  modport slave  (output rx, input data, input valid, input frame_err, input busy);
endinterface

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchronizer for an asynchronous single-bit input.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronized out).
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver, LSB first, midpoint sampling with the system clock.
// Ports: clk, rst (sync, active-high), bus (uart_rx_if.master: rx in;
//        data, valid, frame_err, busy out - all registered).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned clock_frequency = 12000000,
  parameter int unsigned baud_rate       = 9600
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_if.master     bus
);

  localparam int unsigned CPB  = cycles_per_bit(clock_frequency, baud_rate);
  localparam int unsigned HALF = half_bit(clock_frequency, baud_rate);
  localparam logic [BAUD_W-1:0] CPB_LD  = BAUD_W'(CPB - 1);
  localparam logic [BAUD_W-1:0] HALF_LD = BAUD_W'(HALF);

  logic              rx_s;
  logic [2:0]        state, state_nxt;
  logic [BAUD_W-1:0] baud_cnt, baud_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_nxt;
  logic [7:0]        shift_reg, shift_nxt;
  logic [7:0]        data_q, data_nxt;
  logic              valid_q, valid_nxt;
  logic              ferr_q, ferr_nxt;
  logic              busy_q, busy_nxt;
  logic              baud_zero_c;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
      data_q    <= data_nxt;
      valid_q   <= valid_nxt;
      ferr_q    <= ferr_nxt;
      busy_q    <= busy_nxt;
    end
  end

  assign baud_zero_c = (baud_cnt == '0);

  // Next-state, counter and output decode.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_reg;
    data_nxt  = data_q;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;

    // Non-idle states all count down one bit slot at a time.
    if (state != IDLE && state != BREAK && !baud_zero_c) begin
      baud_nxt = baud_cnt - BAUD_W'(1);
    end

    case (state)
      IDLE: begin
        if (!rx_s) begin
          baud_nxt  = HALF_LD;
          state_nxt = START;
        end
      end
      START: begin
        if (baud_zero_c) begin
          // Still low at mid start bit: genuine frame; otherwise a glitch.
          if (!rx_s) begin
            baud_nxt  = CPB_LD;
            bit_nxt   = '0;
            state_nxt = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (baud_zero_c) begin
          shift_nxt[bit_cnt] = rx_s;
          baud_nxt           = CPB_LD;
          if (bit_cnt == BIT_W'(7)) begin
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (baud_zero_c) begin
          if (rx_s) begin
            data_nxt  = shift_reg;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        // A held-low line must not be mistaken for a new start bit.
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Purpose: directed self-checking bench for uart_rx (CPB=16, HALF=8).
module tb_uart_rx;

  logic clk;
  logic rst;
  uart_rx_if bus ();

  uart_rx #(.clock_frequency(16), .baud_rate(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Output monitor, sampled on the falling edge.
  int         cyc = 0;
  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         last_vcyc = 0;
  int         prev_vcyc = 0;
  logic [7:0] last_vdata = 8'h00;
  logic [7:0] prev_vdata = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      valid_cnt  = valid_cnt + 1;
      prev_vcyc  = last_vcyc;
      last_vcyc  = cyc;
      prev_vdata = last_vdata;
      last_vdata = bus.data;
    end
    if (bus.frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
    if (bus.valid === 1'b1 && bus.frame_err === 1'b1) both_cnt = both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ideal transmitter: bit i ends at floor((i+1)*p100/100) cycles (p100 = period*100).
  task automatic send_bits(input logic [9:0] bits, input int nbits, input int p100);
    for (int i = 0; i < nbits; i++) begin
      bus.rx = bits[i];
      repeat (((i + 1) * p100) / 100 - (i * p100) / 100) @(negedge clk);
    end
  endtask

  function automatic logic [9:0] frame(input logic [7:0] d, input logic stop);
    return {stop, d, 1'b0};
  endfunction

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  int v0;
  int f0;

  initial begin
    bus.rx = 1'b1;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_data", 32'(bus.data), 32'h00);
    chk("rst_valid", 32'(bus.valid), 32'h0);
    chk("rst_ferr", 32'(bus.frame_err), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);

    // 1: single byte A5
    idle(20);
    send_bits(frame(8'hA5, 1'b1), 10, 1600);
    idle(40);
    chk("t1_valid_cnt", 32'(valid_cnt), 32'd1);
    chk("t1_data", 32'(bus.data), 32'hA5);
    chk("t1_ferr_cnt", 32'(ferr_cnt), 32'd0);
    chk("t1_busy", 32'(bus.busy), 32'h0);

    // 2: false start, 5 low cycles
    v0 = valid_cnt; f0 = ferr_cnt;
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    chk("t2_busy_hi", 32'(bus.busy), 32'h1);
    @(negedge clk);
    idle(30);
    chk("t2_busy_lo", 32'(bus.busy), 32'h0);
    chk("t2_no_valid", 32'(valid_cnt), 32'(v0));
    chk("t2_no_ferr", 32'(ferr_cnt), 32'(f0));

    // 3: byte 3C with stop low, line low for 2 bit times after data
    idle(20);
    v0 = valid_cnt;
    send_bits(frame(8'h3C, 1'b0), 10, 1600);
    bus.rx = 1'b0;
    repeat (16) @(negedge clk);
    chk("t3_ferr_cnt", 32'(ferr_cnt), 32'd1);
    chk("t3_data_held", 32'(bus.data), 32'hA5);
    chk("t3_no_valid", 32'(valid_cnt), 32'(v0));
    chk("t3_busy_break", 32'(bus.busy), 32'h1);
    idle(8);
    chk("t3_busy_lo", 32'(bus.busy), 32'h0);
    chk("t3_ferr_once", 32'(ferr_cnt), 32'd1);

    // 4: back-to-back 00, FF
    idle(20);
    v0 = valid_cnt;
    send_bits(frame(8'h00, 1'b1), 10, 1600);
    send_bits(frame(8'hFF, 1'b1), 10, 1600);
    idle(40);
    chk("t4_valid_cnt", 32'(valid_cnt), 32'(v0 + 2));
    chk("t4_first", 32'(prev_vdata), 32'h00);
    chk("t4_second", 32'(bus.data), 32'hFF);
    chk("t4_gap", 32'(last_vcyc - prev_vcyc), 32'd160);

    // 5: reset during bit 4 of 55, then 81
    v0 = valid_cnt; f0 = ferr_cnt;
    send_bits(frame(8'h55, 1'b1), 5, 1600);
    bus.rx = 1'b1;
    repeat (8) @(negedge clk);
    chk("t5_busy_pre", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_data", 32'(bus.data), 32'h00);
    chk("t5_rst_valid", 32'(bus.valid), 32'h0);
    chk("t5_rst_ferr", 32'(bus.frame_err), 32'h0);
    chk("t5_rst_busy", 32'(bus.busy), 32'h0);
    idle(200);
    chk("t5_no_valid", 32'(valid_cnt), 32'(v0));
    chk("t5_no_ferr", 32'(ferr_cnt), 32'(f0));
    send_bits(frame(8'h81, 1'b1), 10, 1600);
    idle(40);
    chk("t5_valid_cnt", 32'(valid_cnt), 32'(v0 + 1));
    chk("t5_data", 32'(bus.data), 32'h81);

    // 6: baud skew +/-3%, byte C3
    v0 = valid_cnt;
    send_bits(frame(8'hC3, 1'b1), 10, 1648);
    idle(40);
    chk("t6_slow_valid", 32'(valid_cnt), 32'(v0 + 1));
    chk("t6_slow_data", 32'(bus.data), 32'hC3);
    bus.rx = 1'b1;
    send_bits(frame(8'h5A, 1'b1), 10, 1600);
    idle(40);
    chk("t6_reload", 32'(bus.data), 32'h5A);
    send_bits(frame(8'hC3, 1'b1), 10, 1552);
    idle(40);
    chk("t6_fast_valid", 32'(valid_cnt), 32'(v0 + 3));
    chk("t6_fast_data", 32'(bus.data), 32'hC3);

    chk("never_both", 32'(both_cnt), 32'd0);
    chk("ferr_total", 32'(ferr_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
